// File: rtl/sa_ctrl_if.sv
// Control interface between a job master and the systolic-array sequencer.
// Holds the PE mux-select type shared by the sequencer and its users.
// Optional build macro: SA_CTRL_PERF_EN adds job_cnt_o / busy_cyc_o.
package sa_ctrl_pkg;
  // Per-PE operand routing; value 0 is the idle/passthrough encoding
  typedef enum logic [1:0] {
    MUX_PASSTHROUGH = 2'd0,
    MUX_LOAD        = 2'd1,
    MUX_PROCESS     = 2'd2
  } input_mux_t;
endpackage

interface sa_ctrl_if import sa_ctrl_pkg::*; #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int KW   = 5
);
  logic            start_i;
  logic [KW-1:0]   k_len_i;
  logic            abort_i;
  logic            busy_o;
  logic            done_o;
  input_mux_t      mux_o       [ROWS][COLS];
  logic            add_zero_o  [ROWS][COLS];
  logic            acc_valid_o [COLS];
`ifdef SA_CTRL_PERF_EN
  logic [15:0]     job_cnt_o;
  logic [31:0]     busy_cyc_o;

  modport master (
    output start_i, k_len_i, abort_i,
    input  busy_o, done_o, mux_o, add_zero_o, acc_valid_o, job_cnt_o, busy_cyc_o
  );
  modport slave (
    input  start_i, k_len_i, abort_i,
    output busy_o, done_o, mux_o, add_zero_o, acc_valid_o, job_cnt_o, busy_cyc_o
  );
`else
  modport master (
    output start_i, k_len_i, abort_i,
    input  busy_o, done_o, mux_o, add_zero_o, acc_valid_o
  );
  modport slave (
    input  start_i, k_len_i, abort_i,
    output busy_o, done_o, mux_o, add_zero_o, acc_valid_o
  );
`endif
endinterface

// File: rtl/sa_ctrl.sv
// Systolic-array job sequencer: IDLE -> LOAD (weights shift in) ->
// PROCESS (vectors stream, accumulators capture with per-column skew) ->
// DONE. All outputs decode from registered state/cnt only.
// Optional build macro: SA_CTRL_PERF_EN adds job and busy-cycle counters.
module sa_ctrl import sa_ctrl_pkg::*; #(
  parameter  int ROWS  = 4,
  parameter  int COLS  = 4,
  parameter  int MAX_K = 16,
  localparam int KW    = $clog2(MAX_K + 1)
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  sa_ctrl_if.slave  bus
);
  // cnt must reach MAX_K+ROWS+COLS without wrapping
  localparam int CW = $clog2(MAX_K + ROWS + COLS + 1);
  localparam logic [KW-1:0] K_MAX     = KW'(MAX_K);
  localparam logic [CW-1:0] LOAD_LAST = CW'(ROWS - 1);
  localparam logic [CW-1:0] PROC_OFS  = CW'(ROWS + COLS - 3);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_PROCESS, ST_DONE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [KW-1:0]   kl_reg, kl_next;
  logic [KW-1:0]   kl_in;
  logic [CW-1:0]   kl_ext;
  logic [CW-1:0]   proc_last;
  logic            in_load, in_process;
  input_mux_t      mux_sel;

  assign kl_in     = (bus.k_len_i > K_MAX) ? K_MAX : bus.k_len_i;
  assign kl_ext    = CW'(kl_reg);
  assign proc_last = kl_ext + PROC_OFS;

  // State, cycle counter and latched vector count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      kl_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      kl_reg    <= kl_next;
    end
  end

  // Next-state decode; abort outranks normal progress, start only seen in IDLE
  always_comb begin
    state_next = state_reg;
    kl_next    = kl_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (bus.start_i) begin
          kl_next    = kl_in;
          state_next = (kl_in != '0) ? ST_LOAD : ST_DONE;
        end
      end
      ST_LOAD: begin
        if (bus.abort_i)                state_next = ST_IDLE;
        else if (cnt_reg == LOAD_LAST)  state_next = ST_PROCESS;
      end
      ST_PROCESS: begin
        if (bus.abort_i)                state_next = ST_IDLE;
        else if (cnt_reg == proc_last)  state_next = ST_DONE;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    // Counter restarts on every state entry and idles at zero
    cnt_next = (state_next != state_reg || state_reg == ST_IDLE) ? '0 : cnt_reg + CW'(1);
  end

  assign in_load    = (state_reg == ST_LOAD);
  assign in_process = (state_reg == ST_PROCESS);
  assign bus.busy_o = in_load | in_process;
  assign bus.done_o = (state_reg == ST_DONE);

  // Common mux select: weights latch on the final LOAD cycle
  always_comb begin
    mux_sel = MUX_PASSTHROUGH;
    if (in_process)                         mux_sel = MUX_PROCESS;
    else if (in_load && cnt_reg == LOAD_LAST) mux_sel = MUX_LOAD;
  end

  // Top row has no north neighbour during PROCESS, so it adds zero
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      assign bus.mux_o[gi][gj]      = mux_sel;
      assign bus.add_zero_o[gi][gj] = (gi == 0) ? in_process : 1'b0;
    end
  end

  // Column c sees its first result after ROWS-1+c cycles, then kl results
  for (genvar gi = 0; gi < COLS; gi++) begin : g_acc
    localparam logic [CW-1:0] ACC_LO = CW'(ROWS - 1 + gi);
    assign bus.acc_valid_o[gi] = in_process && (cnt_reg >= ACC_LO) &&
                                 (cnt_reg < ACC_LO + kl_ext);
  end

`ifdef SA_CTRL_PERF_EN
  logic [15:0] job_cnt_reg;
  logic [31:0] busy_cyc_reg;

  // Completed-job count wraps; busy-cycle count saturates
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      job_cnt_reg  <= '0;
      busy_cyc_reg <= '0;
    end else begin
      if (bus.done_o)
        job_cnt_reg <= job_cnt_reg + 16'd1;
      if (bus.busy_o && busy_cyc_reg != '1)
        busy_cyc_reg <= busy_cyc_reg + 32'd1;
    end
  end

  assign bus.job_cnt_o  = job_cnt_reg;
  assign bus.busy_cyc_o = busy_cyc_reg;
`endif
endmodule

// File: tb/tb_sa_ctrl.sv
// Scoreboard bench for sa_ctrl: each job pushes its expected per-cycle
// output trace, which is popped and compared on falling clock edges.
module tb_sa_ctrl;
  import sa_ctrl_pkg::*;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int MAX_K = 16;
  localparam int KW    = $clog2(MAX_K + 1);

  typedef struct packed {
    logic             busy;
    logic             done;
    logic [1:0]       mux;
    logic             az0;
    logic [COLS-1:0]  acc;
  } exp_t;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk_i = ~clk_i;

  sa_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .KW(KW)) bus();

  sa_ctrl #(.ROWS(ROWS), .COLS(COLS), .MAX_K(MAX_K)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  // Expected trace of one job, ending in the IDLE cycle that follows it
  task automatic push_job(input int k, input int abort_idx);
    exp_t tr[$];
    exp_t e;
    int   kl = (k > MAX_K) ? MAX_K : k;
    int   p  = kl + ROWS + COLS - 2;
    if (kl > 0) begin
      for (int i = 0; i < ROWS; i++) begin
        e = '0; e.busy = 1'b1;
        e.mux = (i == ROWS - 1) ? 2'd1 : 2'd0;
        tr.push_back(e);
      end
      for (int i = 0; i < p; i++) begin
        e = '0; e.busy = 1'b1; e.mux = 2'd2; e.az0 = 1'b1;
        for (int c = 0; c < COLS; c++)
          e.acc[c] = (i >= ROWS - 1 + c) && (i < ROWS - 1 + c + kl);
        tr.push_back(e);
      end
    end
    if (abort_idx >= 0) begin
      while (tr.size() > abort_idx + 1) void'(tr.pop_back());
    end else begin
      e = '0; e.done = 1'b1;
      tr.push_back(e);
    end
    e = '0;
    tr.push_back(e);
    foreach (tr[i]) sb_q.push_back(tr[i]);
  endtask

  task automatic run_job(input string name, input int k, input int abort_idx,
                         input int noise_idx, input bit abort_at_start);
    exp_t e, obs;
    bit   bad;
    int   pulses[COLS];
    int   kl = (k > MAX_K) ? MAX_K : k;
    int   i = 0;
    foreach (pulses[c]) pulses[c] = 0;
    push_job(k, abort_idx);
    @(negedge clk_i);
    bus.start_i = 1'b1;
    bus.k_len_i = k[KW-1:0];
    bus.abort_i = abort_at_start;
    while (sb_q.size() > 0) begin
      @(negedge clk_i);
      e = sb_q.pop_front();
      bad = 1'b0;
      if (bus.busy_o !== e.busy || bus.done_o !== e.done) bad = 1'b1;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          if (bus.mux_o[r][c] !== e.mux) bad = 1'b1;
          if (bus.add_zero_o[r][c] !== ((r == 0) ? e.az0 : 1'b0)) bad = 1'b1;
        end
      for (int c = 0; c < COLS; c++) begin
        if (bus.acc_valid_o[c] !== e.acc[c]) bad = 1'b1;
        obs.acc[c] = bus.acc_valid_o[c];
        if (bus.acc_valid_o[c] === 1'b1) pulses[c]++;
      end
      obs.busy = bus.busy_o; obs.done = bus.done_o;
      obs.mux = bus.mux_o[0][0]; obs.az0 = bus.add_zero_o[0][0];
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s cyc%0d: got busy=%b done=%b mux=%0d az0=%b acc=%b, want busy=%b done=%b mux=%0d az0=%b acc=%b",
                 name, i, obs.busy, obs.done, obs.mux, obs.az0, obs.acc,
                 e.busy, e.done, e.mux, e.az0, e.acc);
      end
      bus.start_i = (i == noise_idx);
      bus.k_len_i = (i == noise_idx) ? KW'(1) : k[KW-1:0];
      bus.abort_i = (i == abort_idx);
      i++;
    end
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    if (abort_idx < 0) begin
      for (int c = 0; c < COLS; c++) begin
        checks++;
        if (pulses[c] !== kl) begin
          errors++;
          $display("FAIL %s pulses col%0d: got %0d, want %0d", name, c, pulses[c], kl);
        end
      end
    end
    $display("job %s k=%0d kl=%0d abort_idx=%0d cycles=%0d", name, k, kl, abort_idx, i);
  endtask

  task automatic test_reset();
    bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.k_len_i = '0;
    #12;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.mux_o[ROWS-1][COLS-1] !== MUX_PASSTHROUGH
        || bus.add_zero_o[0][0] !== 1'b0 || bus.acc_valid_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b mux=%0d az=%b acc=%b, want all 0",
               bus.busy_o, bus.done_o, bus.mux_o[ROWS-1][COLS-1], bus.add_zero_o[0][0], bus.acc_valid_o[0]);
    end
`ifdef SA_CTRL_PERF_EN
    checks++;
    if (bus.job_cnt_o !== 16'd0 || bus.busy_cyc_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_perf: got job=%0d busy_cyc=%0d, want 0 0", bus.job_cnt_o, bus.busy_cyc_o);
    end
`endif
    @(negedge clk_i);
    rst_ni = 1'b1;
    // Requests or aborts only while idle must not start anything on their own
    bus.abort_i = 1'b1;
    repeat (3) @(negedge clk_i);
    bus.abort_i = 1'b0;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_abort: got busy=%b done=%b, want 0 0", bus.busy_o, bus.done_o);
    end
    $display("job reset_and_idle done");
  endtask

  task automatic test_reset_mid_load();
    int dones = 0;
    int busys = 0;
    @(negedge clk_i);
    bus.start_i = 1'b1; bus.k_len_i = KW'(3);
    @(negedge clk_i);
    bus.start_i = 1'b0;
    repeat (3) @(negedge clk_i);
    // Now in final LOAD cycle: busy and LOAD mux select are active
    checks++;
    if (bus.busy_o !== 1'b1 || bus.mux_o[0][0] !== MUX_LOAD) begin
      errors++;
      $display("FAIL pre_reset_load: got busy=%b mux=%0d, want 1 %0d", bus.busy_o, bus.mux_o[0][0], MUX_LOAD);
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.mux_o[0][0] !== MUX_PASSTHROUGH) begin
      errors++;
      $display("FAIL async_reset: got busy=%b done=%b mux=%0d, want 0 0 0", bus.busy_o, bus.done_o, bus.mux_o[0][0]);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (20) begin
      @(negedge clk_i);
      if (bus.done_o === 1'b1) dones++;
      if (bus.busy_o === 1'b1) busys++;
    end
    checks++;
    if (dones !== 0 || busys !== 0) begin
      errors++;
      $display("FAIL reset_discard: got done_cycles=%0d busy_cycles=%0d, want 0 0", dones, busys);
    end
    $display("job reset_mid_load done");
  endtask

`ifdef SA_CTRL_PERF_EN
  task automatic test_perf();
    run_job("perf1", 2, -1, -1, 1'b0);
    run_job("perf2", 2, -1, -1, 1'b0);
    run_job("perf3", 2, -1, -1, 1'b0);
    checks++;
    if (bus.job_cnt_o !== 16'd3) begin
      errors++;
      $display("FAIL perf_jobs: got %0d, want 3", bus.job_cnt_o);
    end
    checks++;
    if (bus.busy_cyc_o !== 32'd36) begin
      errors++;
      $display("FAIL perf_busy: got %0d, want 36", bus.busy_cyc_o);
    end
  endtask
`endif

  task automatic test_basic();
    run_job("k4", 4, -1, -1, 1'b0);
    run_job("k1", 1, -1, -1, 1'b0);
  endtask

  task automatic test_k_zero();
    run_job("k0", 0, -1, -1, 1'b0);
  endtask

  task automatic test_k_clamp();
    run_job("k31_clamp", 31, -1, -1, 1'b0);
    run_job("k16_max", 16, -1, -1, 1'b0);
  endtask

  task automatic test_abort();
    run_job("abort_proc5", 4, ROWS + 5, -1, 1'b0);
    run_job("after_abort", 3, -1, -1, 1'b0);
    run_job("abort_load1", 6, 1, -1, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_job("start_in_load", 5, -1, 1, 1'b0);
    run_job("start_in_proc", 2, -1, ROWS + 2, 1'b0);
  endtask

  task automatic test_start_abort_together();
    run_job("start_wins", 2, -1, -1, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++)
      run_job("b2b", int'($urandom_range(0, 20)), -1, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_reset_mid_load();
`ifdef SA_CTRL_PERF_EN
    test_perf();
`endif
    test_basic();
    test_k_zero();
    test_k_clamp();
    test_abort();
    test_start_ignored();
    test_start_abort_together();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
